// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with synchronous flush.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'('h13)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_hold;
  logic [1:0]       w_count_nxt;
  logic             w_acc;
  logic             w_ret;
  assign out_valid   = r_count != 2'd0;
  assign out_data    = r_head;
  assign count       = r_count;
  assign w_acc       = in_valid && in_ready && !flush;
  assign w_ret       = out_valid && out_ready;
  assign w_count_nxt = flush ? 2'd0 : r_count + {1'b0, w_acc} - {1'b0, w_ret};
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  // in_ready is precomputed from the next count so out_ready never reaches it combinationally
  assign in_ready    = r_in_ready;
  assign w_head_hold = (r_count == 2'd2 && w_ret) ? r_skid : r_head;
  always_ff @(posedge clk) begin
    r_in_ready <= rst ? 1'b1 : (w_count_nxt != 2'd2);
    if (w_acc && r_count == 2'd1 && !w_ret) r_skid <= in_data;
  end
`else
  assign in_ready    = (r_count == 2'd0) || out_ready;
  assign w_head_hold = r_head;
`endif
  always_ff @(posedge clk) begin
    r_count <= rst ? 2'd0 : w_count_nxt;
    if (rst || flush) r_head <= FLUSH_VAL;
    else if (w_acc && (r_count == 2'd0 || w_ret)) r_head <= in_data;
    else r_head <= w_head_hold;
  end
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed plus random stimulus against a queue-based model of pipe_stage.
module tb_pipe_stage;
  localparam int W = 64;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   count;
  logic [W-1:0] q[$];
  logic [W-1:0] last;
  int           checks = 0;
  int           errors = 0;

  pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then advance the model
  task automatic step(input string tag, input logic r, input logic f, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    logic exp_rdy, acc, ret;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
    check({tag, ".valid"}, W'(out_valid), W'(q.size() != 0));
    check({tag, ".data"}, out_data, q.size() != 0 ? q[0] : last);
    check({tag, ".count"}, W'(count), W'(q.size()));
    check({tag, ".in_ready"}, W'(in_ready), W'(exp_rdy));
    acc = iv && exp_rdy && !f;
    ret = q.size() != 0 && ordy;
    if (r || f) begin
      q.delete();
      last = W'('h13);
    end else begin
      if (ret) last = q.pop_front();
      if (acc) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    q.delete();
    last = W'('h13);
    rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    @(negedge clk);
    step("reset0", 1, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step("stream", 0, 0, 1, W'(i), 1);
    step("stream_drain", 0, 0, 0, 0, 1);
    step("drained", 0, 0, 0, 0, 1);
    step("stall_a", 0, 0, 1, W'('hA), 0);
    step("stall_b", 0, 0, 1, W'('hB), 0);
    step("stall_c_held", 0, 0, 1, W'('hC), 0);
    step("stall_c_held2", 0, 0, 1, W'('hC), 0);
    step("stall_release", 0, 0, 1, W'('hC), 1);
    step("stall_release2", 0, 0, 1, W'('hC), 1);
    for (int i = 0; i < 4; i++) step("stall_drain", 0, 0, 0, 0, 1);
    step("flush_load", 0, 0, 1, W'('h5), 0);
    step("flush_acc", 0, 1, 1, W'('h6), 0);
    step("flush_after", 0, 0, 0, 0, 1);
    step("flush_after2", 0, 0, 0, 0, 1);
    step("rf_load", 0, 0, 1, W'('h7), 0);
    step("rf_all", 1, 1, 1, W'('h8), 1);
    step("rf_after", 0, 0, 0, 0, 1);
    step("rf_after2", 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom), {$urandom, $urandom}, 1'($urandom));
    for (int i = 0; i < 200; i++)
      step("toggle", 0, 0, 1'b1, {$urandom, $urandom}, 1'(i & 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits.
REQ-002 SHALL have parameter FLUSH_VAL, default WIDTH'h13 (NOP), payload value driven after reset/flush.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream holds a valid payload.
REQ-006 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  stage presents a valid payload.
REQ-009 SHALL have port out_ready  input  1  downstream consumes this cycle; low = stall.
REQ-010 SHALL have port out_data  output  WIDTH  head payload.
REQ-011 SHALL have port flush  input  1  discard all held and incoming payloads.
REQ-012 SHALL have port count  output  2  entries held (0..1 or 0..2 per Configuration).

Function
REQ-013 SHALL accept a payload on a cycle where in_valid && in_ready && !flush; SHALL retire the head on a cycle where out_valid && out_ready.
REQ-014 SHALL deliver payloads in acceptance order, none dropped or duplicated absent flush.
REQ-015 SHALL present an accepted payload on out_data/out_valid the cycle after acceptance (latency 1) when the stage was empty.
REQ-016 SHALL hold out_data and out_valid stable while out_valid && !out_ready && !flush.
REQ-017 SHALL implement states EMPTY (count 0), ONE (count 1) and, with skid, TWO (count 2); out_valid = (count != 0).
REQ-018 Transitions: accept-only -> count+1; retire-only -> count-1; accept and retire same cycle -> count unchanged, new payload becomes head next cycle when ONE, or shifts behind remaining entry when TWO.
REQ-019 SHALL, on flush, force count 0, out_valid 0, out_data FLUSH_VAL on the next cycle; flush SHALL win over simultaneous accept and retire (accepted payload discarded).
REQ-020 SHALL still assert out_valid the flush cycle itself if held before (downstream may retire it); flush affects only next state.
REQ-021 SHALL keep out_data equal to last retired payload when EMPTY after normal drain (not FLUSH_VAL).
REQ-022 SHALL never accept when full: in_ready low guarantees in_valid ignored.

Reset
REQ-023 SHALL, while rst high at posedge clk, set count 0, out_valid 0, out_data FLUSH_VAL, in_ready 1 from the following cycle.
REQ-024 SHALL give rst priority over flush, accept and retire; reset mid-transfer discards all entries.

Configuration
REQ-025 SHALL honour macro PIPE_STAGE_SKID_EN.
REQ-026 With PIPE_STAGE_SKID_EN defined: two entries (head + skid), in_ready = (count != 2) driven from a register only, no combinational path out_ready -> in_ready; full throughput sustained with out_ready toggling.
REQ-027 Without PIPE_STAGE_SKID_EN: one entry, in_ready = (count == 0) || out_ready (combinational), count never exceeds 1, TWO unreachable.

Verification
REQ-028 Reset then idle: rst 1 for 2 cycles -> count 0, out_valid 0, out_data 0x13, in_ready 1.
REQ-029 Streaming: in_valid 1, data 1,2,3,4 on consecutive cycles, out_ready 1 -> out_data 1,2,3,4 one cycle later each, count 1 steady.
REQ-030 Stall (skid on): send 0xA,0xB with out_ready 0 -> count 2, in_ready 0, 0xC held off; raise out_ready -> 0xA,0xB,0xC in order, no loss.
REQ-031 Stall (skid off): out_ready 0 with 0xA held -> in_ready 0 same cycle out_ready low; in_ready 1 same cycle out_ready high.
REQ-032 Flush with accept: count 1 holding 0x5, in_valid 1 data 0x6, flush 1 -> next cycle count 0, out_valid 0, out_data 0x13; 0x6 never appears.
REQ-033 Reset vs flush vs accept same cycle: rst 1, flush 1, in_valid 1 -> reset state per REQ-023, no payload emitted.
